// File: rtl/pin_target_emu.sv
// pin_target_emu: emulated target board that prompts over UART for a 4-byte PIN and answers ok/invalid
module pin_target_emu #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] PIN          = 32'h34333231,
  parameter logic [7:0]  PROMPT_CHAR  = 8'h3a,
  parameter logic [7:0]  FAIL_CHAR    = 8'h69,
  parameter logic [7:0]  OK_CHAR      = 8'h4f,
  parameter int          PROMPT_DELAY = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic        tgt_rst,
  output logic        unlocked,
  output logic [15:0] attempts,
  output logic        frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = $clog2(PROMPT_DELAY + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {HOLD, DELAY, PROMPT, COLLECT, CHECK, RESP, DONE} state_t;
  rx_st_t          rx_st_q;
  logic [1:0]      rx_sync_q;
  logic            rx_prev_q;
  logic            rx_s;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            tx_q;
  logic            tx_busy_q;
  logic            tx_done_q;
  logic            tx_load;
  logic [7:0]      tx_data;
  logic [8:0]      tx_sh_q;
  logic [3:0]      tx_bit_q;
  logic [CW-1:0]   tx_cnt_q;
  state_t          state_q, state_d;
  logic [DW-1:0]   dly_q;
  logic [1:0]      idx_q;
  logic [31:0]     got_q;
  logic            ok_q;
  logic            unlocked_q;
  logic [15:0]     attempts_q;
  assign rx_s      = rx_sync_q[1];
  assign tx        = tx_q;
  assign unlocked  = unlocked_q;
  assign attempts  = attempts_q;
  assign frame_err = frame_err_q;
  // UART receiver: start re-checked at half bit, then data and stop sampled one bit apart
  always_ff @(posedge clk) begin
    rx_sync_q   <= {rx_sync_q[0], rx};
    rx_prev_q   <= rx_s;
    rx_valid_q  <= 1'b0;
    frame_err_q <= 1'b0;
    if (rst) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_st_q   <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_q + 1'b1;
      case (rx_st_q)
        R_IDLE: if (rx_prev_q && !rx_s) begin
          rx_st_q  <= R_START;
          rx_cnt_q <= '0;
        end
        R_START: if (rx_cnt_q == HALF) begin
          rx_st_q  <= rx_s ? R_IDLE : R_DATA;
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
        end
        R_DATA: if (rx_cnt_q == FULL) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
        end
        R_STOP: if (rx_cnt_q == FULL) begin
          rx_st_q     <= R_IDLE;
          rx_valid_q  <= rx_s;
          frame_err_q <= !rx_s;
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end
  // UART transmitter: start, 8 data LSB first, stop; tgt_rst aborts the frame and idles the line
  always_ff @(posedge clk) begin
    tx_done_q <= 1'b0;
    if (rst || tgt_rst) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (tx_load) begin
      tx_q      <= 1'b0;
      tx_busy_q <= 1'b1;
      tx_sh_q   <= {1'b1, tx_data};
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else if (tx_busy_q) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
      if (tx_cnt_q == FULL) begin
        tx_cnt_q <= '0;
        tx_bit_q <= tx_bit_q + 1'b1;
        tx_q     <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
          tx_q      <= 1'b1;
        end
      end
    end
  end
  // Session next-state and transmit requests; tgt_rst overrides everything
  always_comb begin
    state_d = state_q;
    tx_load = 1'b0;
    tx_data = state_q == PROMPT ? PROMPT_CHAR : (ok_q ? OK_CHAR : FAIL_CHAR);
    case (state_q)
      HOLD:    state_d = DELAY;
      DELAY:   state_d = dly_q == DW'(PROMPT_DELAY - 1) ? PROMPT : DELAY;
      PROMPT:  begin
        tx_load = !tx_busy_q && !tx_done_q;
        state_d = tx_done_q ? COLLECT : PROMPT;
      end
      COLLECT: state_d = rx_valid_q && idx_q == 2'd3 ? CHECK : COLLECT;
      CHECK:   state_d = RESP;
      RESP:    begin
        tx_load = !tx_busy_q && !tx_done_q;
        state_d = tx_done_q ? DONE : RESP;
      end
      default: state_d = state_q;
    endcase
    if (tgt_rst) begin
      state_d = HOLD;
      tx_load = 1'b0;
    end
  end
  // State register, delay counter, PIN capture and the sticky/saturating result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      dly_q      <= '0;
      idx_q      <= '0;
      got_q      <= '0;
      ok_q       <= 1'b0;
      unlocked_q <= 1'b0;
      attempts_q <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= state_q == DELAY ? dly_q + 1'b1 : '0;
      if (tgt_rst || state_q == HOLD) idx_q <= '0;
      else if (state_q == COLLECT && rx_valid_q) begin
        got_q[{idx_q, 3'b000} +: 8] <= rx_sh_q;
        idx_q <= idx_q + 1'b1;
      end
      if (state_q == CHECK) begin
        ok_q       <= got_q == PIN;
        unlocked_q <= unlocked_q | (got_q == PIN);
        if (attempts_q != 16'hFFFF) attempts_q <= attempts_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pin_target_emu.sv
// tb_pin_target_emu: directed sessions against the PIN target emulator
module tb_pin_target_emu;
  localparam int CPB = 4;
  localparam int PD  = 8;
  typedef struct {
    logic [31:0] pin;
    logic [7:0]  resp;
    logic [15:0] att;
    logic        unl;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        tgt_rst = 1'b1;
  logic        tx;
  logic        unlocked;
  logic        frame_err;
  logic [15:0] attempts;
  int          pass_n = 0;
  int          total_n = 0;
  int          fe_n = 0;
  vec_t        vecs[4];
  pin_target_emu #(.CLKS_PER_BIT(CPB), .PROMPT_DELAY(PD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tgt_rst(tgt_rst),
    .unlocked(unlocked), .attempts(attempts), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) fe_n++;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wait_low(output int n);
    n = 0;
    while (n < 300 && tx !== 1'b0) begin
      @(posedge clk); #1;
      n++;
    end
    if (tx !== 1'b0) n = -1;
  endtask
  task automatic decode(output logic [8:0] r);
    logic s0;
    logic [7:0] b;
    repeat (2) @(posedge clk);
    #1 s0 = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 b[i] = tx;
    end
    repeat (CPB) @(posedge clk);
    #1 r = {~s0 & tx, b};
  endtask
  task automatic rx_frame(output int n, output logic [8:0] r);
    wait_low(n);
    r = '0;
    if (n >= 0) decode(r);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic send_pin(input logic [31:0] p);
    for (int i = 0; i < 4; i++) send_byte(p[8*i +: 8], 1'b1);
  endtask
  task automatic open_prompt(input string tag);
    int n;
    logic [8:0] r;
    @(negedge clk);
    tgt_rst = 1'b1;
    repeat (2) @(negedge clk);
    tgt_rst = 1'b0;
    @(posedge clk); #1;
    rx_frame(n, r);
    chk({tag, " prompt latency"}, n, 9);
    chk({tag, " prompt char"}, {23'd0, r}, {23'd0, 1'b1, 8'h3a});
  endtask
  task automatic finish_session(input string tag, input logic [7:0] c, input logic [15:0] a, input logic u);
    int n;
    logic [8:0] r;
    rx_frame(n, r);
    chk({tag, " response"}, {23'd0, r}, {23'd0, 1'b1, c});
    chk({tag, " attempts"}, attempts, a);
    chk({tag, " unlocked"}, unlocked, u);
  endtask
  initial begin
    int n;
    int lows;
    int fe0;
    vecs[0] = '{32'h35333231, 8'h69, 16'd1, 1'b0};
    vecs[1] = '{32'h34333231, 8'h4f, 16'd2, 1'b1};
    vecs[2] = '{32'h30303030, 8'h69, 16'd3, 1'b1};
    vecs[3] = '{32'h31323334, 8'h69, 16'd4, 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset tx", tx, 1);
    chk("reset unlocked", unlocked, 0);
    chk("reset attempts", attempts, 0);
    chk("reset frame_err", frame_err, 0);
    for (int i = 0; i < 4; i++) begin
      open_prompt($sformatf("vec%0d", i));
      send_pin(vecs[i].pin);
      finish_session($sformatf("vec%0d", i), vecs[i].resp, vecs[i].att, vecs[i].unl);
    end
    send_pin(32'h34333231);
    wait_low(n);
    chk("done silent", n, -1);
    chk("done attempts", attempts, 4);
    open_prompt("abort");
    send_pin(32'h30303030);
    wait_low(n);
    chk("abort response started", n >= 0, 1);
    repeat (5) @(posedge clk);
    #1 tgt_rst = 1'b1;
    @(posedge clk); #1;
    chk("abort tx high", tx, 1);
    lows = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    chk("abort tx stays idle", lows, 0);
    chk("abort attempts", attempts, 5);
    chk("abort unlocked kept", unlocked, 1);
    open_prompt("partial");
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    fork
      send_byte(8'h33, 1'b1);
      begin
        repeat (10) @(posedge clk);
        #1 tgt_rst = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1 chk("partial attempts", attempts, 5);
    open_prompt("after partial");
    send_pin(32'h34333231);
    finish_session("after partial", 8'h4f, 16'd6, 1'b1);
    open_prompt("frame");
    fe0 = fe_n;
    send_byte(8'h31, 1'b0);
    repeat (4) @(negedge clk);
    chk("frame_err pulse", fe_n - fe0, 1);
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch no frame_err", fe_n - fe0, 1);
    send_pin(32'h34333231);
    finish_session("after bad bytes", 8'h4f, 16'd7, 1'b1);
    @(posedge clk);
    force dut.attempts_q = 16'hFFFF;
    @(posedge clk);
    release dut.attempts_q;
    open_prompt("sat");
    send_pin(32'h39393939);
    finish_session("sat", 8'h69, 16'hFFFF, 1'b1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
